// File: rtl/division_pkg.sv
// Shared types and constants for the sequential restoring divider.
package division_pkg;
  localparam int unsigned DIV_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    OP,
    LAST,
    DONE
  } state_t;
endpackage

// File: rtl/division_step.sv
// One restoring-division iteration: shift in the next dividend bit, compare, subtract.
module division_step #(
  parameter int unsigned N = 32
) (
  input  logic [N-1:0] rh,
  input  logic [N-1:0] rl,
  input  logic [N-1:0] d,
  output logic [N-1:0] rh_next,
  output logic [N-1:0] rl_next
);
  logic [N:0] shifted;
  logic [N:0] diff;
  logic       qbit;

  // N+1-bit compare keeps divisors with the MSB set correct.
  always_comb begin
    shifted = {rh, rl[N-1]};
    diff    = shifted - {1'b0, d};
    qbit    = (shifted >= {1'b0, d});
    rh_next = qbit ? diff[N-1:0] : shifted[N-1:0];
    rl_next = {rl[N-2:0], qbit};
  end
endmodule

// File: rtl/division_core.sv
// Sequential unsigned divider, one quotient bit per clock, with a one-cycle done pulse.
module division_core
  import division_pkg::*;
#(
  parameter int unsigned N = DIV_W
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         start_i,
  input  logic [N-1:0] dividend_i,
  input  logic [N-1:0] divisor_i,
  output logic [N-1:0] quotient_o,
  output logic [N-1:0] remainder_o,
  output logic         done_o
);
  localparam int unsigned CW = $clog2(N + 1);

  state_t        state_q, state_d;
  logic [N-1:0]  rh_q, rl_q, d_q;
  logic [N-1:0]  rh_nxt, rl_nxt;
  logic [CW-1:0] n_q;
  logic          load, iter, finish;

  division_step #(.N(N)) u_step (
    .rh      (rh_q),
    .rl      (rl_q),
    .d       (d_q),
    .rh_next (rh_nxt),
    .rl_next (rl_nxt)
  );

  // Next-state and datapath control.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    iter    = 1'b0;
    finish  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          load    = 1'b1;
          state_d = OP;
        end
      end
      OP: begin
        iter = 1'b1;
        if (n_q == CW'(2)) state_d = LAST;
      end
      LAST: begin
        iter    = 1'b1;
        finish  = 1'b1;
        state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      rh_q        <= '0;
      rl_q        <= '0;
      d_q         <= '0;
      n_q         <= '0;
      quotient_o  <= '0;
      remainder_o <= '0;
      done_o      <= 1'b0;
    end else begin
      state_q <= state_d;
      done_o  <= (state_q == DONE);
      if (load) begin
        d_q  <= divisor_i;
        rh_q <= '0;
        rl_q <= dividend_i;
        n_q  <= CW'(N);
      end
      if (iter) begin
        rh_q <= rh_nxt;
        rl_q <= rl_nxt;
        n_q  <= n_q - CW'(1);
      end
      if (finish) begin
        quotient_o  <= rl_nxt;
        remainder_o <= rh_nxt;
      end
    end
  end
endmodule

// File: tb/tb_division_core.sv
// Self-checking bench for division_core: directed table, corner sequences, random vs. arithmetic model.
module tb_division_core;
  localparam int unsigned N = 32;
  localparam int unsigned LAT = N + 1;
  localparam int unsigned BOUND = 2 * N + 10;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [N-1:0] dividend = '0;
  logic [N-1:0] divisor = '0;
  logic [N-1:0] quotient, remainder;
  logic         done;

  int vectors = 0;
  int miscompares = 0;

  division_core #(.N(N)) dut (
    .clk_i       (clk),
    .reset_i     (reset),
    .start_i     (start),
    .dividend_i  (dividend),
    .divisor_i   (divisor),
    .quotient_o  (quotient),
    .remainder_o (remainder),
    .done_o      (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] a;
    logic [N-1:0] b;
    int           hold;
    int           pulses;
    logic [N-1:0] q;
    logic [N-1:0] r;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Plain-arithmetic reference: divide by zero yields all ones and the dividend.
  function automatic logic [N-1:0] ref_q(input logic [N-1:0] a, input logic [N-1:0] b);
    return (b == '0) ? '1 : a / b;
  endfunction
  function automatic logic [N-1:0] ref_r(input logic [N-1:0] a, input logic [N-1:0] b);
    return (b == '0) ? a : a % b;
  endfunction

  // Issue one start (held for `hold` cycles), scramble inputs afterwards, watch done.
  task automatic run_div(input string name, input logic [N-1:0] a, input logic [N-1:0] b,
                         input int hold, input int exp_pulses,
                         input logic [N-1:0] exp_q, input logic [N-1:0] exp_r);
    int first;
    int pulses;
    logic [N-1:0] q_at_done, r_at_done;
    first = 0;
    pulses = 0;
    q_at_done = '0;
    r_at_done = '0;
    @(negedge clk);
    start = 1'b1;
    dividend = a;
    divisor = b;
    for (int c = 1; c <= int'(BOUND); c++) begin
      @(negedge clk);
      if (done) begin
        pulses++;
        if (first == 0) begin
          first = c;
          q_at_done = quotient;
          r_at_done = remainder;
        end
      end
      if (c == hold) begin
        start = 1'b0;
        dividend = $urandom;
        divisor = $urandom;
      end
    end
    check({name, " latency"}, 64'(first - 1), 64'(LAT));
    check({name, " pulses"}, 64'(pulses), 64'(exp_pulses));
    check({name, " quotient"}, 64'(q_at_done), 64'(exp_q));
    check({name, " remainder"}, 64'(r_at_done), 64'(exp_r));
    check({name, " held q"}, 64'(quotient), 64'(exp_q));
  endtask

  vec_t table_v[$];

  initial begin
    table_v.push_back('{a: 32'd1000000,   b: 32'd2000000,   hold: 2, pulses: 1, q: 32'd0,          r: 32'd1000000});
    table_v.push_back('{a: 32'h10000007,  b: 32'd1,         hold: 1, pulses: 1, q: 32'h10000007,   r: 32'd0});
    table_v.push_back('{a: 32'd100,       b: 32'd7,         hold: 1, pulses: 1, q: 32'd14,         r: 32'd2});
    table_v.push_back('{a: 32'hFFFFFFFF,  b: 32'h80000001,  hold: 3, pulses: 1, q: 32'd1,          r: 32'h7FFFFFFE});
    table_v.push_back('{a: 32'hFFFFFFFF,  b: 32'hFFFFFFFF,  hold: 1, pulses: 1, q: 32'd1,          r: 32'd0});
    table_v.push_back('{a: 32'd1234,      b: 32'd0,         hold: 1, pulses: 1, q: 32'hFFFFFFFF,   r: 32'd1234});
    table_v.push_back('{a: 32'hFFFFFFFF,  b: 32'h00010000,  hold: 1, pulses: 1, q: 32'h0000FFFF,   r: 32'h0000FFFF});
    // Start held through DONE: a second division starts from the IDLE cycle.
    table_v.push_back('{a: 32'd500,       b: 32'd16,        hold: int'(N) + 3, pulses: 2, q: 32'd31, r: 32'd4});

    // Reset held 8 cycles with start low.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("reset outputs", {31'd0, done, quotient}, 64'd0);
      check("reset remainder", 64'(remainder), 64'd0);
    end
    reset = 1'b0;

    foreach (table_v[i])
      run_div($sformatf("vec%0d", i), table_v[i].a, table_v[i].b, table_v[i].hold,
              table_v[i].pulses, table_v[i].q, table_v[i].r);

    // Reset in the middle of an operation aborts it silently.
    begin
      int pulses;
      pulses = 0;
      @(negedge clk);
      start = 1'b1;
      dividend = 32'hDEADBEEF;
      divisor = 32'd3;
      for (int c = 1; c <= int'(BOUND); c++) begin
        @(negedge clk);
        if (done) pulses++;
        if (c == 1) start = 1'b0;
        if (c == 10) reset = 1'b1;
        if (c == 11) reset = 1'b0;
      end
      check("abort pulses", 64'(pulses), 64'd0);
      check("abort quotient", 64'(quotient), 64'd0);
      check("abort remainder", 64'(remainder), 64'd0);
    end
    run_div("after_abort", 32'd9, 32'd3, 1, 1, 32'd3, 32'd0);

    // Random operands against the arithmetic model, biased toward small divisors and zero.
    for (int i = 0; i < 40; i++) begin
      logic [N-1:0] a, b;
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 3))
        0: b = b >> $urandom_range(1, 31);
        1: if ($urandom_range(0, 3) == 0) b = '0;
        2: a = a >> $urandom_range(0, 31);
        default: ;
      endcase
      run_div($sformatf("rand%0d", i), a, b, int'($urandom_range(1, 5)), 1, ref_q(a, b), ref_r(a, b));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
